// File: rtl/prio_enc_drain_pkg.sv
// Shared types and helpers for the draining priority encoder.
// State encoding plus the clog2 helper used to size the index output.
package prio_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ZERO  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_drain_if.sv
// Request-in / index-out handshake bundle for prio_enc_drain.
// master = request source and index consumer, slave = the encoder block.
interface prio_enc_drain_if
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int IDX_W = clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_none;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_none, out_last, busy
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_none, out_last, busy
    );

endinterface

// File: rtl/prio_enc_drain_comb.sv
// Combinational WIDTH-bit priority encoder with single-bit detect.
// MSB wins by default; LSB_FIRST_EN makes the lowest set bit win.
module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]        vec,
    output logic [clog2(WIDTH)-1:0] idx,
    output logic                    any,
    output logic                    one_hot
);
    localparam int IDX_W = clog2(WIDTH);

    // Later loop iterations override earlier ones, so the scan
    // direction decides which set bit wins.
    always_comb begin
        idx = '0;
`ifdef LSB_FIRST_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
`else
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
`endif
    end

    assign any     = |vec;
    assign one_hot = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/prio_enc_drain.sv
// Sequential priority encoder: captures a request vector, then emits one
// index per beat. Build with LSB_FIRST_EN for lowest-index-first ordering.
module prio_enc_drain
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_enc_drain_if.slave  bus
);
    localparam int IDX_W = clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_one_hot;
    logic             w_drain;
    logic             w_zero;

    prio_enc_comb #(.WIDTH(WIDTH)) u_enc (
        .vec     (r_pending),
        .idx     (w_idx),
        .any     (w_any),
        .one_hot (w_one_hot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (|bus.in_vec) begin
                            r_pending <= bus.in_vec;
                            r_state   <= DRAIN;
                        end else begin
                            r_state   <= ZERO;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        r_pending <= r_pending & ~(WIDTH'(1) << w_idx);
                        if (w_one_hot) r_state <= IDLE;
                    end
                end
                ZERO: begin
                    if (bus.out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never on in_* or out_ready.
    assign w_drain       = (r_state == DRAIN) && w_any;
    assign w_zero        = (r_state == ZERO);
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = w_drain || w_zero;
    assign bus.out_idx   = w_drain ? w_idx : '0;
    assign bus.out_none  = w_zero;
    assign bus.out_last  = (w_drain && w_one_hot) || w_zero;

endmodule
